// File: rtl/ext_stream_fifo.sv
// Register-mapped dual FIFO on a ghostbus external port: host pushes TX, reads/pops RX.
// Optional TX->RX loopback is enabled by defining EXT_STREAM_FIFO_LOOPBACK_EN.
module ext_stream_fifo #(
    parameter int aw         = 2,
    parameter int dw         = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [aw-1:0] addr,
    input  logic [dw-1:0] din,
    input  logic          we,
    output logic [dw-1:0] dout,
    output logic [dw-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    input  logic [dw-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [dw-1:0] tx_mem [DEPTH];
    logic [dw-1:0] rx_mem [DEPTH];

    ptr_t tx_wp;
    ptr_t tx_rp;
    ptr_t rx_wp;
    ptr_t rx_rp;
    ptr_t rx_level;

    logic tx_ovf;
    logic rx_udf;
    logic lpbk;
    logic rdy;

    logic tx_empty;
    logic tx_full;
    logic rx_empty;
    logic rx_full;

    logic sel_tx;
    logic sel_rx;
    logic sel_st;
    logic sel_lv;

    logic wr_tx;
    logic wr_rx;
    logic wr_st;

    logic lb_move;
    logic tx_pop;
    logic tx_push;
    logic tx_ovf_set;
    logic rx_push;
    logic rx_pop;
    logic rx_udf_set;

    logic [dw-1:0] rx_head;
    logic [dw-1:0] rx_wdata;
    logic [dw-1:0] rd_val;
    logic [4:0]    status;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp == {~tx_rp[PW-1], tx_rp[PW-2:0]});
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp == {~rx_rp[PW-1], rx_rp[PW-2:0]});
    assign rx_level = rx_wp - rx_rp;

    assign sel_tx = (addr[1:0] == 2'd0);
    assign sel_rx = (addr[1:0] == 2'd1);
    assign sel_st = (addr[1:0] == 2'd2);
    assign sel_lv = (addr[1:0] == 2'd3);

    assign wr_tx = we & sel_tx;
    assign wr_rx = we & sel_rx;
    assign wr_st = we & sel_st;

    assign m_tdata = tx_mem[tx_rp[PW-2:0]];
    assign rx_head = rx_mem[rx_rp[PW-2:0]];

`ifdef EXT_STREAM_FIFO_LOOPBACK_EN
    assign lb_move = lpbk & ~tx_empty & ~rx_full;

    // Loopback mode bit, host-writable through the status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lpbk <= 1'b0;
        end else if (wr_st) begin
            lpbk <= din[4];
        end
    end
`else
    assign lb_move = 1'b0;
    assign lpbk    = 1'b0;
`endif

    // Streams are gated off while looping back so only internal moves occur
    assign m_tvalid = ~tx_empty & ~lpbk;
    assign s_tready = rdy & ~rx_full & ~lpbk;

    // A pop in the same cycle frees the slot a full-FIFO push lands in
    assign tx_pop     = (m_tvalid & m_tready) | lb_move;
    assign tx_push    = wr_tx & (~tx_full | tx_pop);
    assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;

    assign rx_push    = (s_tvalid & s_tready) | lb_move;
    assign rx_wdata   = lb_move ? m_tdata : s_tdata;
    assign rx_pop     = wr_rx & ~rx_empty;
    assign rx_udf_set = wr_rx & rx_empty;

    assign status = {lpbk, rx_udf, tx_ovf, rx_empty, tx_full};

    // Storage arrays carry no reset; the pointers alone define contents
    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wp[PW-2:0]] <= din;
        end
        if (rx_push) begin
            rx_mem[rx_wp[PW-2:0]] <= rx_wdata;
        end
    end

    // TX pointers advance on accepted push and on stream or loopback pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) begin
                tx_wp <= tx_wp + 1'b1;
            end
            if (tx_pop) begin
                tx_rp <= tx_rp + 1'b1;
            end
        end
    end

    // RX pointers advance on stream or loopback push and on host pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) begin
                rx_wp <= rx_wp + 1'b1;
            end
            if (rx_pop) begin
                rx_rp <= rx_rp + 1'b1;
            end
        end
    end

    // Sticky error flags; a new event beats a same-cycle W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(wr_st & din[2]));
            rx_udf <= rx_udf_set | (rx_udf & ~(wr_st & din[3]));
        end
    end

    // Holds s_tready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy <= 1'b0;
        end else begin
            rdy <= 1'b1;
        end
    end

    // Read mux from the pre-edge FIFO state
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_tx: rd_val = '0;
            sel_rx: rd_val = rx_empty ? '0 : rx_head;
            sel_st: rd_val = dw'(status);
            sel_lv: rd_val = dw'(rx_level);
        endcase
    end

    // Registered bus read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= rd_val;
        end
    end

endmodule

// File: tb/tb_ext_stream_fifo.sv
// Bench for ext_stream_fifo: directed scenarios plus random traffic against a queue model.
// Loopback checks follow EXT_STREAM_FIFO_LOOPBACK_EN.
module tb_ext_stream_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] addr;
    logic [7:0] din;
    logic       we;
    logic [7:0] dout;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;

    always #5 clk = ~clk;

    ext_stream_fifo #(
        .aw(2),
        .dw(8),
        .DEPTH_LOG2(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .din(din),
        .we(we),
        .dout(dout),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] seen[$];
    bit         m_ovf;
    bit         m_udf;
    bit         m_lpbk;
    bit         m_rdy;
    logic [7:0] exp_dout;
    logic [7:0] v;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] status();
        return {3'b000, m_lpbk, m_udf, m_ovf,
                rxq.size() == 0, txq.size() == 16};
    endfunction

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_ovf = 0;
        m_udf = 0;
        m_lpbk = 0;
        m_rdy = 0;
        exp_dout = 8'h00;
    endtask

    // One clock: check stream outputs, advance model, check dout after edge
    task automatic step();
        bit tv, tp, lb, tfull, rempty, spush;
        logic [7:0] nd;
        int a;
        a = int'(addr);
        tv = !m_lpbk && txq.size() > 0;
        check("m_tvalid", m_tvalid, tv);
        if (tv) check("m_tdata", m_tdata, txq[0]);
        check("s_tready", s_tready, m_rdy && !m_lpbk && rxq.size() < 16);
        case (a)
            0: nd = 8'h00;
            1: nd = (rxq.size() > 0) ? rxq[0] : 8'h00;
            2: nd = status();
            default: nd = 8'(rxq.size());
        endcase
        tp = tv && m_tready;
        if (tp) seen.push_back(m_tdata);
        lb = m_lpbk && txq.size() > 0 && rxq.size() < 16;
        spush = s_tvalid && m_rdy && !m_lpbk && rxq.size() < 16;
        tfull = (txq.size() == 16);
        rempty = (rxq.size() == 0);
        if (we && a == 1) begin
            if (rempty) m_udf = 1;
            else void'(rxq.pop_front());
        end
        if (lb) rxq.push_back(txq.pop_front());
        else if (tp) void'(txq.pop_front());
        if (spush) rxq.push_back(s_tdata);
        if (we && a == 0) begin
            if (!tfull || tp || lb) txq.push_back(din);
            else m_ovf = 1;
        end
        if (we && a == 2) begin
            if (din[2]) m_ovf = 0;
            if (din[3]) m_udf = 0;
`ifdef EXT_STREAM_FIFO_LOOPBACK_EN
            m_lpbk = din[4];
`endif
        end
        m_rdy = 1;
        exp_dout = nd;
        @(negedge clk);
        check("dout", dout, exp_dout);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        addr = a;
        din = d;
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] r);
        addr = a;
        we = 1'b0;
        step();
        r = dout;
    endtask

    task automatic idle(input int n);
        addr = 2'd0;
        we = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        rst_n = 1'b0;
        addr = 2'd2;
        din = 8'h00;
        we = 1'b0;
        m_tready = 1'b0;
        s_tdata = 8'h00;
        s_tvalid = 1'b0;
        model_reset();

        repeat (5) begin
            @(negedge clk);
            check("rst_dout", dout, 8'h00);
            check("rst_m_tvalid", m_tvalid, 1'b0);
            check("rst_s_tready", s_tready, 1'b0);
        end
        rst_n = 1'b1;

        rd_reg(2'd2, v);
        check("status_after_rst", v, 8'h02);
        rd_reg(2'd3, v);
        check("level_after_rst", v, 8'h00);
        check("s_tready_after_rst", s_tready, 1'b1);

        for (int i = 0; i < 16; i++) wr_reg(2'd0, 8'h11 + 8'(i));
        rd_reg(2'd2, v);
        check("tx_full", v, 8'h03);
        wr_reg(2'd0, 8'hAA);
        rd_reg(2'd2, v);
        check("tx_ovf", v, 8'h07);
        seen.delete();
        m_tready = 1'b1;
        idle(18);
        m_tready = 1'b0;
        check("tx_count", seen.size(), 16);
        for (int i = 0; i < 16 && i < seen.size(); i++)
            check("tx_order", seen[i], 8'h11 + 8'(i));
        wr_reg(2'd2, 8'h04);
        rd_reg(2'd2, v);
        check("ovf_w1c", v, 8'h02);

        s_tvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_tdata = 8'(i + 1);
            idle(1);
        end
        s_tvalid = 1'b0;
        check("rx_full_stall", s_tready, 1'b0);
        rd_reg(2'd3, v);
        check("level_16", v, 8'h10);
        rd_reg(2'd1, v);
        check("rx_head_1", v, 8'h01);
        wr_reg(2'd1, 8'h00);
        rd_reg(2'd1, v);
        check("rx_head_2", v, 8'h02);
        rd_reg(2'd3, v);
        check("level_15", v, 8'h0F);
        repeat (15) wr_reg(2'd1, 8'h00);
        rd_reg(2'd3, v);
        check("level_0", v, 8'h00);

        wr_reg(2'd1, 8'h00);
        rd_reg(2'd2, v);
        check("rx_udf", v, 8'h0A);
        rd_reg(2'd3, v);
        check("udf_level", v, 8'h00);
        wr_reg(2'd2, 8'h08);
        rd_reg(2'd2, v);
        check("udf_w1c", v, 8'h02);
        s_tvalid = 1'b1;
        s_tdata = 8'h77;
        wr_reg(2'd1, 8'h00);
        s_tvalid = 1'b0;
        rd_reg(2'd2, v);
        check("udf_with_push", v, 8'h08);
        rd_reg(2'd3, v);
        check("udf_push_level", v, 8'h01);
        rd_reg(2'd1, v);
        check("udf_push_data", v, 8'h77);
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd2, 8'h0C);
        rd_reg(2'd2, v);
        check("clean_status", v, 8'h02);

        for (int i = 0; i < 16; i++) wr_reg(2'd0, 8'h60 + 8'(i));
        seen.delete();
        m_tready = 1'b1;
        wr_reg(2'd0, 8'h55);
        idle(20);
        m_tready = 1'b0;
        check("simul_count", seen.size(), 17);
        if (seen.size() == 17) begin
            check("simul_first", seen[0], 8'h60);
            check("simul_last", seen[16], 8'h55);
        end
        rd_reg(2'd2, v);
        check("simul_no_ovf", v, 8'h02);

`ifdef EXT_STREAM_FIFO_LOOPBACK_EN
        wr_reg(2'd2, 8'h10);
        rd_reg(2'd2, v);
        check("lpbk_set", v, 8'h12);
        m_tready = 1'b1;
        wr_reg(2'd0, 8'h3C);
        wr_reg(2'd0, 8'hC3);
        idle(3);
        check("lpbk_m_tvalid", m_tvalid, 1'b0);
        rd_reg(2'd1, v);
        check("lpbk_rx0", v, 8'h3C);
        wr_reg(2'd1, 8'h00);
        rd_reg(2'd1, v);
        check("lpbk_rx1", v, 8'hC3);
        wr_reg(2'd1, 8'h00);
        m_tready = 1'b0;
        wr_reg(2'd2, 8'h00);
        rd_reg(2'd2, v);
        check("lpbk_clear", v, 8'h02);
`else
        wr_reg(2'd2, 8'h10);
        rd_reg(2'd2, v);
        check("lpbk_absent", v, 8'h02);
`endif

        seen.delete();
        repeat (400) begin
            addr = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 1) == 0);
            din = 8'($urandom);
            m_tready = ($urandom_range(0, 3) == 0);
            s_tvalid = ($urandom_range(0, 3) == 0);
            s_tdata = 8'($urandom);
            step();
        end
        repeat (400) begin
            addr = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 2) == 0);
            din = 8'($urandom);
            m_tready = ($urandom_range(0, 3) != 0);
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata = 8'($urandom);
            step();
        end
        we = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;

        wr_reg(2'd2, 8'h0C);
        wr_reg(2'd0, 8'h01);
        wr_reg(2'd0, 8'h02);
        s_tvalid = 1'b1;
        s_tdata = 8'h09;
        idle(2);
        s_tvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dout", dout, 8'h00);
        check("midrst_m_tvalid", m_tvalid, 1'b0);
        check("midrst_s_tready", s_tready, 1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg(2'd2, v);
        check("midrst_status", v, 8'h02);
        rd_reg(2'd3, v);
        check("midrst_level", v, 8'h00);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
